// File: rtl/unidade_load_store.sv
// -----------------------------------------------------------------------------
// unidade_load_store
// Memory-side load/store initiator between the core datapath and a word-wide
// data memory. Handles byte/halfword/word loads (sign- or zero-extended) and
// stores. Sub-word stores are done as read-modify-write. Misaligned or illegal
// requests are rejected without any memory strobe.
//
// Handshake: the core presents Requisicao plus the request fields. A request
// is accepted on a rising edge where Pronto=1 and Requisicao=1. All request
// fields are captured at that edge. While Pronto=0, every request input is
// ignored. Completion is signalled by a one-cycle Valido pulse.
// ErroAlinhamento qualifies that pulse.
//
// Ports
//   Clock, Reset_n        clock, asynchronous active-low reset
//   Requisicao            request (sampled only while Pronto=1)
//   Escrita               1 = store, 0 = load
//   Tamanho               00 byte, 01 halfword, 10 word, 11 illegal
//   SemSinal              loads: 1 zero-extend, 0 sign-extend
//   EnderecoCPU, DadoCPU  byte address, right-aligned store data
//   Pronto, Valido        idle indicator, completion pulse
//   DadoCarregado         load result, held until the next load completes
//   ErroAlinhamento       rejected request (only together with Valido)
//   Endereco              word-aligned memory address
//   DadosEscrita          full word to write
//   MemWrite, MemRead     memory strobes (mutually exclusive)
//   DadosLidos            memory read data (combinational from Endereco)
//   EstadoDepuracao       current FSM state, for observation only
// -----------------------------------------------------------------------------
module unidade_load_store #(
  parameter int LARGURA = 32
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Requisicao,
  input  logic               Escrita,
  input  logic [1:0]         Tamanho,
  input  logic               SemSinal,
  input  logic [LARGURA-1:0] EnderecoCPU,
  input  logic [LARGURA-1:0] DadoCPU,
  output logic               Pronto,
  output logic               Valido,
  output logic [LARGURA-1:0] DadoCarregado,
  output logic               ErroAlinhamento,
  output logic [LARGURA-1:0] Endereco,
  output logic [LARGURA-1:0] DadosEscrita,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [LARGURA-1:0] DadosLidos,
  output logic [1:0]         EstadoDepuracao
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LEITURA  = 2'd1,
    ESCRITA  = 2'd2,
    RESPOSTA = 2'd3
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   endereco_q, endereco_d;
  logic [1:0]           faixa_q, faixa_d;        // addr[1:0] of the request
  logic [1:0]           tamanho_q, tamanho_d;
  logic                 escrita_q, escrita_d;
  logic                 sem_sinal_q, sem_sinal_d;
  logic [LARGURA-1:0]   dado_cpu_q, dado_cpu_d;
  logic                 erro_q, erro_d;
  logic [LARGURA-1:0]   dados_escrita_q, dados_escrita_d;
  logic [LARGURA-1:0]   dado_carregado_q, dado_carregado_d;

  logic                 desalinhado;
  logic [7:0]           byte_sel;
  logic [15:0]          meia_sel;
  logic [LARGURA-1:0]   estendido;
  logic [LARGURA-1:0]   mesclado;

  // Decoded directly from the live request; only used at acceptance.
  always_comb begin
    desalinhado = 1'b0;
    case (Tamanho)
      2'b01:   desalinhado = EnderecoCPU[0];
      2'b10:   desalinhado = (EnderecoCPU[1:0] != 2'b00);
      2'b11:   desalinhado = 1'b1;
      default: desalinhado = 1'b0;
    endcase
  end

  // Lane extraction and extension for loads.
  always_comb begin
    byte_sel = DadosLidos[7:0];
    case (faixa_q)
      2'd0:    byte_sel = DadosLidos[7:0];
      2'd1:    byte_sel = DadosLidos[15:8];
      2'd2:    byte_sel = DadosLidos[23:16];
      default: byte_sel = DadosLidos[31:24];
    endcase
    meia_sel = faixa_q[1] ? DadosLidos[31:16] : DadosLidos[15:0];
    case (tamanho_q)
      2'b00:   estendido = {{(LARGURA-8){~sem_sinal_q & byte_sel[7]}}, byte_sel};
      2'b01:   estendido = {{(LARGURA-16){~sem_sinal_q & meia_sel[15]}}, meia_sel};
      default: estendido = DadosLidos;
    endcase
  end

  // Sub-word store merge: untouched lanes keep the word just read.
  always_comb begin
    mesclado = DadosLidos;
    if (tamanho_q == 2'b00) begin
      case (faixa_q)
        2'd0:    mesclado[7:0]   = dado_cpu_q[7:0];
        2'd1:    mesclado[15:8]  = dado_cpu_q[7:0];
        2'd2:    mesclado[23:16] = dado_cpu_q[7:0];
        default: mesclado[31:24] = dado_cpu_q[7:0];
      endcase
    end else if (faixa_q[1]) begin
      mesclado[31:16] = dado_cpu_q[15:0];
    end else begin
      mesclado[15:0] = dado_cpu_q[15:0];
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d         = estado_q;
    endereco_d       = endereco_q;
    faixa_d          = faixa_q;
    tamanho_d        = tamanho_q;
    escrita_d        = escrita_q;
    sem_sinal_d      = sem_sinal_q;
    dado_cpu_d       = dado_cpu_q;
    erro_d           = erro_q;
    dados_escrita_d  = dados_escrita_q;
    dado_carregado_d = dado_carregado_q;
    case (estado_q)
      OCIOSO: begin
        if (Requisicao) begin
          endereco_d  = {EnderecoCPU[LARGURA-1:2], 2'b00};
          faixa_d     = EnderecoCPU[1:0];
          tamanho_d   = Tamanho;
          escrita_d   = Escrita;
          sem_sinal_d = SemSinal;
          dado_cpu_d  = DadoCPU;
          erro_d      = desalinhado;
          if (desalinhado) begin
            estado_d = RESPOSTA;
          end else if (Escrita && (Tamanho == 2'b10)) begin
            dados_escrita_d = DadoCPU;
            estado_d        = ESCRITA;
          end else begin
            estado_d = LEITURA;
          end
        end
      end
      LEITURA: begin
        if (escrita_q) begin
          dados_escrita_d = mesclado;
          estado_d        = ESCRITA;
        end else begin
          dado_carregado_d = estendido;
          estado_d         = RESPOSTA;
        end
      end
      ESCRITA:  estado_d = RESPOSTA;
      default:  estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q         <= OCIOSO;
      endereco_q       <= '0;
      faixa_q          <= 2'b00;
      tamanho_q        <= 2'b00;
      escrita_q        <= 1'b0;
      sem_sinal_q      <= 1'b0;
      dado_cpu_q       <= '0;
      erro_q           <= 1'b0;
      dados_escrita_q  <= '0;
      dado_carregado_q <= '0;
    end else begin
      estado_q         <= estado_d;
      endereco_q       <= endereco_d;
      faixa_q          <= faixa_d;
      tamanho_q        <= tamanho_d;
      escrita_q        <= escrita_d;
      sem_sinal_q      <= sem_sinal_d;
      dado_cpu_q       <= dado_cpu_d;
      erro_q           <= erro_d;
      dados_escrita_q  <= dados_escrita_d;
      dado_carregado_q <= dado_carregado_d;
    end
  end

  // Outputs come only from registered state; the strobes are state decodes,
  // so an asynchronous reset drops them immediately.
  assign Pronto          = (estado_q == OCIOSO);
  assign Valido          = (estado_q == RESPOSTA);
  assign ErroAlinhamento = (estado_q == RESPOSTA) && erro_q;
  assign MemRead         = (estado_q == LEITURA);
  assign MemWrite        = (estado_q == ESCRITA);
  assign Endereco        = endereco_q;
  assign DadosEscrita    = dados_escrita_q;
  assign DadoCarregado   = dado_carregado_q;
  assign EstadoDepuracao = estado_q;

endmodule

// File: doc/unidade_load_store.md
# unidade_load_store

- Memory-side initiator for `DadosDeMemoria`; sits between the processor datapath and the word-wide data memory.
- Accepts byte, halfword and word load/store requests from the core through a ready/valid handshake.
- Drives `Endereco`/`DadosEscrita`/`MemWrite`/`MemRead` and returns sign- or zero-extended load data.
- Implements sub-word stores as read-modify-write and rejects misaligned accesses without touching memory.

## Interface
- `LARGURA`, default 32: address and data width. Only 32 is supported.
- `Clock`  in  1  sole clock; all state changes on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Requisicao`  in  1  request; sampled only while `Pronto`=1.
- `Escrita`  in  1  1 = store, 0 = load.
- `Tamanho`  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `SemSinal`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `EnderecoCPU`  in  32  byte address.
- `DadoCPU`  in  32  store data, right-aligned.
- `Pronto`  out  1  idle; a request will be accepted this cycle.
- `Valido`  out  1  one-cycle completion pulse.
- `DadoCarregado`  out  32  load result; held until the next load completes.
- `ErroAlinhamento`  out  1  high only together with `Valido` for rejected requests.
- `Endereco`  out  32  word-aligned memory address; bits [1:0] are always 0.
- `DadosEscrita`  out  32  full word to write.
- `MemWrite`  out  1  memory write enable.
- `MemRead`  out  1  memory read enable.
- `DadosLidos`  in  32  memory read data, combinational from `Endereco` when `MemRead`=1.

## Operation
- **States:** OCIOSO, LEITURA, ESCRITA, RESPOSTA.
- **Reset:** state = OCIOSO; `Pronto`=1; `Valido`, `ErroAlinhamento`, `MemWrite`, `MemRead` = 0; `DadoCarregado`, `Endereco`, `DadosEscrita` = 0.
- **OCIOSO:** `Pronto`=1. On `Requisicao`=1, capture all request inputs, then branch:
  - Misaligned or illegal (halfword with addr[0]=1, word with addr[1:0]≠0, `Tamanho`=11): go to RESPOSTA with the error flag set.
  - Load or sub-word store: go to LEITURA.
  - Word store: go to ESCRITA with `DadosEscrita`=`DadoCPU`.
- **LEITURA:** `MemRead`=1; `Endereco` = {addr[31:2], 2'b00}. `DadosLidos` is captured at the closing edge.
  - Load: extract the lane and extend, then go to RESPOSTA.
  - Sub-word store: merge the store data into the captured word, then go to ESCRITA.
- **Lane selection (little-endian):** byte lane = addr[1:0], so byte k occupies bits [8k+7:8k]. Halfword lane = addr[1].
- **Sub-word merge:** lanes other than the target lane keep their `DadosLidos` values.
- **ESCRITA:** `MemWrite`=1, `MemRead`=0; memory writes at the closing edge. Next state RESPOSTA.
- **RESPOSTA:** `Valido`=1; `ErroAlinhamento` = error flag. Next state OCIOSO.
- **Strobe exclusivity:** `MemRead` and `MemWrite` are never high in the same cycle. Both are 0 in OCIOSO and RESPOSTA.
- **Busy window:** `Requisicao` and all request inputs are ignored while `Pronto`=0. Their changes do not affect the transaction in flight.
- **Outputs:** all outputs are registered or decoded from registered state only. There is no combinational path from CPU inputs to memory outputs.

## Timing
- Edge E0 is the edge at which the request is accepted.
- **Load:** LEITURA during E0–E1, `Valido` during E1–E2, `Pronto`=1 after E2. Latency is 2 cycles to `Valido`; throughput is one request per 3 cycles.
- **Word store:** memory written at E1, `Valido` during E1–E2.
- **Sub-word store:** read during E0–E1, memory written at E2, `Valido` during E2–E3.
- **Rejected request:** `Valido` and `ErroAlinhamento` during E0–E1. No memory strobe at any time.
- **Back-to-back:** `Requisicao` held high is accepted again in the first OCIOSO cycle after RESPOSTA.
- **Reset mid-operation:** `Reset_n` falling clears all outputs immediately and abandons the transaction.
  - If this happens during ESCRITA, `MemWrite` is already 0 at the next edge, so no partial write occurs.
  - No `Valido` is issued for the abandoned request.
- **After reset release:** the first request is accepted on the first rising edge where `Reset_n`=1 and `Requisicao`=1.

## Test plan
- **Word store then load:** sw 0x12345678 @8, then lw @8.
  - `MemWrite` is high exactly 1 cycle and `MemRead` never rises during the sw.
  - lw returns `DadoCarregado`=0x12345678 with a single `Valido` pulse 2 cycles after accept.
- **Byte store and loads:** sb 0x000000AB @9 over 0x12345678, then read back.
  - Memory word @8 becomes 0x1234AB78.
  - lb @9 returns 0xFFFFFFAB; lbu @9 returns 0x000000AB.
  - The store's `Valido` arrives 3 cycles after accept.
- **Halfword store and loads:** sh 0x00008001 @10, then read back.
  - Memory word @8 becomes 0x8001AB78.
  - lh @10 returns 0xFFFF8001; lhu @10 returns 0x00008001; lb @8 returns 0x00000078.
- **Rejected requests:** lw @6, sh @3, `Tamanho`=11 @0.
  - Each gives `Valido`=`ErroAlinhamento`=1 for 1 cycle after accept.
  - `MemRead`=`MemWrite`=0 throughout; word @4 is unchanged; `DadoCarregado` keeps its previous value.
- **Reset during write:** word @16 = 0; sw 0xDEADBEEF @16; pull `Reset_n` low mid-ESCRITA.
  - `MemWrite` drops immediately, no `Valido` is issued, and `Pronto`=1.
  - lw @16 after reset release returns 0x00000000.
- **Continuous request:** hold `Requisicao`=1 while toggling `EnderecoCPU` and `DadoCPU` during busy cycles.
  - Exactly one transaction is accepted per OCIOSO visit, using only the values captured at acceptance.
  - `MemRead`/`MemWrite` never overlap.
